// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the EX stage and the iterative multiply/divide sequencer.
interface muldiv_seq_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (output start, op, a, b, flush, input busy, done, result);
    modport slave  (input start, op, a, b, flush, output busy, done, result);
endinterface

// File: rtl/muldiv_seq.sv
// Iterative RV32M sequencer: 1-bit/cycle shift-add multiplier and restoring divider.
// Handshake: start is taken only in IDLE; busy stays high from the accept edge until DONE
// exits; done is a 1-cycle pulse with result valid; flush aborts in any state with no done.
module muldiv_seq #(
    parameter int XLEN      = 32,
    parameter bit FAST_SPEC = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    muldiv_seq_if.slave   bus,
    output logic [1:0]    state_o
);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    state_t            state_q;
    logic [2:0]        op_q;
    logic              sa_q, sb_q, bz_q, spec_q;
    logic [XLEN-1:0]   a_q, opnd_q, result_q;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [CW-1:0]     cnt_q;
    logic              busy_q, done_q;

    // b==0 and DIV-overflow results; op[1] separates REM/REMU from DIV/DIVU.
    function automatic logic [XLEN-1:0] special_val(input logic [2:0] op, input logic [XLEN-1:0] a,
                                                    input logic bz);
        if (op[1]) special_val = bz ? a : '0;
        else       special_val = bz ? '1 : a;
    endfunction

    logic            sa_in, sb_in, bz_in, spec_in;
    logic [XLEN-1:0] mag_a_in, mag_b_in;

    always_comb begin
        sa_in    = !((bus.op == 3'b011) || (bus.op[2] && bus.op[0])) && bus.a[XLEN-1];
        sb_in    = ((bus.op == 3'b000) || (bus.op == 3'b001) || (bus.op == 3'b100) ||
                    (bus.op == 3'b110)) && bus.b[XLEN-1];
        mag_a_in = sa_in ? -bus.a : bus.a;
        mag_b_in = sb_in ? -bus.b : bus.b;
        bz_in    = (bus.b == '0);
        spec_in  = bus.op[2] && (bz_in || (!bus.op[0] && (bus.a == {1'b1, {(XLEN-1){1'b0}}}) &&
                                          (bus.b == '1)));
    end

    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, fin_d;

    // acc holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = acc_q[2*XLEN-1:XLEN-1];
        div_diff  = div_shift - {1'b0, opnd_q};
        if (op_q[2])
            acc_d = {(div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0]),
                     acc_q[XLEN-2:0], ~div_diff[XLEN]};
        else
            acc_d = {mul_sum, acc_q[XLEN-1:1]};

        prod = (sa_q ^ sb_q) ? -acc_d : acc_d;
        quo  = acc_d[XLEN-1:0];
        rem  = acc_d[2*XLEN-1:XLEN];
        case (op_q)
            3'b000:  fin_d = prod[XLEN-1:0];
            3'b100:  fin_d = (sa_q ^ sb_q) ? -quo : quo;
            3'b101:  fin_d = quo;
            3'b110:  fin_d = sa_q ? -rem : rem;
            3'b111:  fin_d = rem;
            default: fin_d = prod[2*XLEN-1:XLEN];
        endcase
        if (spec_q) fin_d = special_val(op_q, a_q, bz_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            bz_q     <= 1'b0;
            spec_q   <= 1'b0;
            a_q      <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (bus.flush) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        op_q   <= bus.op;
                        sa_q   <= sa_in;
                        sb_q   <= sb_in;
                        bz_q   <= bz_in;
                        spec_q <= spec_in;
                        a_q    <= bus.a;
                        opnd_q <= bus.op[2] ? mag_b_in : mag_a_in;
                        acc_q  <= {{XLEN{1'b0}}, (bus.op[2] ? mag_a_in : mag_b_in)};
                        busy_q <= 1'b1;
                        if (FAST_SPEC && spec_in) begin
                            result_q <= special_val(bus.op, bus.a, bz_in);
                            done_q   <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            cnt_q   <= CW'(XLEN);
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        result_q <= fin_d;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign state_o    = state_q;
endmodule
